divider_unit: RTL and testbench

- Sequential unsigned restoring divider for the 64-bit MIPS datapath's multiply/divide unit.
- Captures a 128-bit dividend and a 128-bit divisor after reset is released.
- Produces one quotient bit per clock and raises rdy when the quotient and remainder are valid.
- One-shot per reset: a new division is launched by pulsing reset.

---
 rtl/div_pkg.sv | 17 +
 rtl/div_step.sv | 28 ++
 rtl/divider_unit.sv | 119 +++++++++++
 tb/tb_divider_unit.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/div_pkg.sv
// Shared definitions for the sequential restoring divider of the multiply/divide unit.
// Holds default widths, the controller state encoding and the iteration counter type.
package div_pkg;

    localparam int DIV_WIDTH  = 128;
    localparam int DIV_QWIDTH = 64;
    localparam int DIV_CNT_W  = $clog2(DIV_WIDTH + 1);

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } div_state_t;

    typedef logic [DIV_CNT_W-1:0] div_cnt_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in the next dividend bit, trial-subtract the divisor.
// Purely combinational; the caller registers the partial remainder and quotient bit.
module div_step #(
    parameter int WIDTH = 128
) (
    input  logic [WIDTH-1:0] prem,
    input  logic             din,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] prem_next,
    output logic             qbit
);

    logic [WIDTH:0]   shifted_s;
    logic [WIDTH-1:0] diff_s;

    // Trial subtraction at WIDTH+1 bits; on success the difference is below the divisor, so it fits in WIDTH bits
    always_comb begin
        shifted_s = {prem, din};
        diff_s    = shifted_s[WIDTH-1:0] - divisor;
        qbit      = (shifted_s >= {1'b0, divisor});
        if (qbit) begin
            prem_next = diff_s;
        end else begin
            prem_next = shifted_s[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/divider_unit.sv
// Sequential unsigned restoring divider: one quotient bit per clock, one division per reset release.
// Outputs are written once, on the final iteration, and then held with rdy until reset.
module divider_unit
    import div_pkg::*;
#(
    parameter int WIDTH  = DIV_WIDTH,
    parameter int QWIDTH = DIV_QWIDTH
) (
    output logic [QWIDTH-1:0] quotient,
    output logic [WIDTH-1:0]  remainder,
    output logic              rdy,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              rst,
    input  logic              clk
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    div_state_t       state_r;
    div_state_t       state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [WIDTH-1:0] dividend_r;
    logic [WIDTH-1:0] divisor_r;
    logic [WIDTH-1:0] prem_r;
    logic [WIDTH-1:0] q_r;
    logic [WIDTH-1:0] q_next_s;
    logic [WIDTH-1:0] prem_next_s;
    logic             qbit_s;
    logic             load_s;
    logic             step_s;
    logic             last_s;

    div_step #(.WIDTH(WIDTH)) u_step (
        .prem      (prem_r),
        .din       (dividend_r[WIDTH-1]),
        .divisor   (divisor_r),
        .prem_next (prem_next_s),
        .qbit      (qbit_s)
    );

    assign q_next_s = {q_r[WIDTH-2:0], qbit_s};

    // Controller state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state and datapath strobes; the step taking the counter from 1 to 0 is the last one
    always_comb begin
        state_next_s = state_r;
        load_s       = 1'b0;
        step_s       = 1'b0;
        last_s       = 1'b0;
        case (state_r)
            LOAD: begin
                load_s       = 1'b1;
                state_next_s = BUSY;
            end
            BUSY: begin
                step_s = 1'b1;
                if (cnt_r == CNT_ONE) begin
                    last_s       = 1'b1;
                    state_next_s = DONE;
                end else begin
                    state_next_s = BUSY;
                end
            end
            DONE: begin
                state_next_s = DONE;
            end
            default: begin
                state_next_s = LOAD;
            end
        endcase
    end

    // Operand capture and per-step shift registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r      <= '0;
            dividend_r <= '0;
            divisor_r  <= '0;
            prem_r     <= '0;
            q_r        <= '0;
        end else if (load_s) begin
            cnt_r      <= CNT_LOAD;
            dividend_r <= a;
            divisor_r  <= b;
            prem_r     <= '0;
            q_r        <= '0;
        end else if (step_s) begin
            cnt_r      <= cnt_r - CNT_ONE;
            dividend_r <= {dividend_r[WIDTH-2:0], 1'b0};
            prem_r     <= prem_next_s;
            q_r        <= q_next_s;
        end
    end

    // Result registers, loaded once with the final quotient bit included; quotient keeps only its low bits
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            quotient  <= '0;
            remainder <= '0;
            rdy       <= 1'b0;
        end else if (last_s) begin
            quotient  <= q_next_s[QWIDTH-1:0];
            remainder <= prem_next_s;
            rdy       <= 1'b1;
        end
    end

endmodule

// File: tb/tb_divider_unit.sv
// Scoreboard bench for divider_unit: stimulus queues expected results, a monitor checks them on rdy.
// Also checks reset/abort behaviour, output hold after completion and the exact completion edge.
module tb_divider_unit;

    typedef struct packed {
        logic [63:0]  q;
        logic [127:0] r;
    } exp_t;

    logic [63:0]  quotient;
    logic [127:0] remainder;
    logic         rdy;
    logic [127:0] a;
    logic [127:0] b;
    logic         rst;
    logic         clk;

    int   checks   = 0;
    int   failures = 0;
    int   edge_cnt;
    bit   seen;
    exp_t exp_q[$];

    divider_unit dut (
        .quotient  (quotient),
        .remainder (remainder),
        .rdy       (rdy),
        .a         (a),
        .b         (b),
        .rst       (rst),
        .clk       (clk)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Rising edges since reset release
    always @(posedge clk or negedge rst) begin
        if (!rst) edge_cnt <= 0;
        else      edge_cnt <= edge_cnt + 1;
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: on the first rdy of each run, pop the expected result and compare
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            seen = 1'b0;
        end else if (rdy && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_rdy: actual=rdy_high required=no_result_pending");
            end else begin
                e = exp_q.pop_front();
                chk("quotient", {64'd0, quotient}, {64'd0, e.q});
                chk("remainder", remainder, e.r);
                chk("latency", 128'(edge_cnt), 128'd129);
            end
        end
    end

    // Enter reset (asynchronously, away from a clock edge), check cleared outputs, present operands, release
    task automatic start(input logic [127:0] av, input logic [127:0] bv);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_rdy", {127'd0, rdy}, 128'd0);
        chk("rst_quotient", {64'd0, quotient}, 128'd0);
        chk("rst_remainder", remainder, 128'd0);
        a = av;
        b = bv;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Wait for completion with a bound, scrambling operands mid-run, then check the outputs hold
    task automatic finish_run(input logic [63:0] eq, input logic [127:0] er);
        int n;
        n = 0;
        while (!seen && n < 200) begin
            @(negedge clk);
            #2;
            n++;
            if (edge_cnt == 10) begin
                a = 128'h1234_5678_9abc_def0_0fed_cba9_8765_4321;
                b = 128'd3;
            end
            if (edge_cnt == 128) chk("rdy_low_at_128", {127'd0, rdy}, 128'd0);
        end
        if (!seen) begin
            checks++;
            failures++;
            $display("FAIL timeout: actual=no_rdy_after_%0d_cycles required=rdy", n);
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
            repeat (5) @(negedge clk);
            #2;
            chk("hold_rdy", {127'd0, rdy}, 128'd1);
            chk("hold_quotient", {64'd0, quotient}, {64'd0, eq});
            chk("hold_remainder", remainder, er);
        end
    endtask

    task automatic run(input logic [127:0] av, input logic [127:0] bv,
                       input logic [63:0] eq, input logic [127:0] er);
        exp_q.push_back('{q: eq, r: er});
        start(av, bv);
        finish_run(eq, er);
    endtask

    initial begin
        logic [127:0] ones;
        int n;
        ones = '1;
        rst  = 1'b0;
        a    = 128'd0;
        b    = 128'd0;
        seen = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("init_rdy", {127'd0, rdy}, 128'd0);
        chk("init_quotient", {64'd0, quotient}, 128'd0);
        chk("init_remainder", remainder, 128'd0);

        run(128'd500, 128'd25, 64'd20, 128'd0);
        run(128'd100, 128'd200, 64'd0, 128'd100);
        run(128'd7, 128'd0, 64'hFFFF_FFFF_FFFF_FFFF, 128'd7);
        run(128'h1_0000_0000_0000_0005, 128'd1, 64'd5, 128'd0);
        run(ones, ones, 64'd1, 128'd0);
        run(ones, 128'h8000_0000_0000_0000_0000_0000_0000_0001, 64'd1,
            128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE);

        // Abort a division at edge 50, then start a fresh one with new operands
        start(128'd500, 128'd25);
        n = 0;
        while (edge_cnt < 50 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        chk("abort_edge", 128'(edge_cnt), 128'd50);
        rst = 1'b0;
        #1;
        chk("abort_rdy", {127'd0, rdy}, 128'd0);
        chk("abort_quotient", {64'd0, quotient}, 128'd0);
        chk("abort_remainder", remainder, 128'd0);
        a = 128'd99;
        b = 128'd10;
        exp_q.push_back('{q: 64'd9, r: 128'd9});
        @(negedge clk);
        rst = 1'b1;
        finish_run(64'd9, 128'd9);

        chk("queue_empty", 128'(exp_q.size()), 128'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
